// File: rtl/bus2st_ser.sv
// bus2st_ser
// Serializes wide bus words (read from memory) into an 8-bit Avalon-ST
// stream with sop/eop framing for the turbo decoder input. A 2-word buffer
// decouples bus back-pressure from st_ready.
//
// Ports:
//   clk_st     single clock for the whole block
//   rst        asynchronous reset, active-high
//   bus_data   bus word; symbol k = bus_data[k*ST +: ST], symbol 0 sent first
//   bus_first  marks bus_data as the first word of a turbo packet
//   bus_en     word valid; transfer when bus_en && bus_ready
//   bus_ready  at least one buffer slot is free (registered)
//   st_ready   Avalon-ST ready, ready latency 0
//   st_data    symbol
//   st_valid   symbol valid
//   st_sop     first symbol of a packet
//   st_eop     last symbol of a packet
//   st_error   framing error, qualified with st_eop
//   pkt_cnt    (only with BUS2ST_PKT_CNT_EN) count of accepted eop beats
//
// Optional feature macro: BUS2ST_PKT_CNT_EN adds the pkt_cnt output.
module bus2st_ser #(
   parameter int ST_PER_BUS       = 512,
   parameter int ST               = 8,
   parameter int NUM_ST_PER_BUS   = ST_PER_BUS / ST,
   parameter int ST_PER_TURBO_PKT = 128
) (
   input  logic                  clk_st,
   input  logic                  rst,
   input  logic [ST_PER_BUS-1:0] bus_data,
   input  logic                  bus_first,
   input  logic                  bus_en,
   output logic                  bus_ready,
   input  logic                  st_ready,
   output logic [ST-1:0]         st_data,
   output logic                  st_valid,
   output logic                  st_sop,
   output logic                  st_eop,
`ifdef BUS2ST_PKT_CNT_EN
   output logic [15:0]           pkt_cnt,
`endif
   output logic                  st_error
);

   localparam int BUS_PER_PKT = ST_PER_TURBO_PKT / NUM_ST_PER_BUS;
   localparam int SYM_W = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
   localparam int BUS_W = (BUS_PER_PKT > 1) ? $clog2(BUS_PER_PKT) : 1;
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(NUM_ST_PER_BUS - 1);
   localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_PER_PKT - 1);

   typedef enum logic {IDLE, SEND} state_t;
   state_t state, state_nxt;

   logic [ST_PER_BUS-1:0] mem_data [2];
   logic [1:0]            mem_first;
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            count, count_nxt;
   logic [SYM_W-1:0]      sym_cnt;
   logic [BUS_W-1:0]      bus_cnt;
   logic                  err_flag, err_nxt;
   logic                  wr, pop, adv, emit, sym_last;
   logic                  sop_nxt, eop_nxt;
   logic [ST_PER_BUS-1:0] head_data;
   logic                  head_first;

   // SEND means the buffer holds at least one word. In IDLE the buffer is
   // empty, so the incoming word is bypassed straight to the serializer;
   // this gives the one-cycle accept-to-first-symbol latency.
   always_comb begin
      state_nxt  = state;
      wr         = bus_en && bus_ready;
      adv        = !st_valid || st_ready;
      head_data  = bus_data;
      head_first = bus_first;
      if (state == SEND) begin
         head_data  = mem_data[rd_ptr];
         head_first = mem_first[rd_ptr];
      end
      emit      = adv && ((state == SEND) || wr);
      sym_last  = (sym_cnt == SYM_LAST);
      pop       = emit && sym_last;
      sop_nxt   = (sym_cnt == '0) && (bus_cnt == '0);
      eop_nxt   = sym_last && (bus_cnt == BUS_LAST);
      // Sticky error: restart at sop, accumulate a word-position mismatch
      // on the first symbol of each word.
      err_nxt   = (sop_nxt ? 1'b0 : err_flag) |
                  ((sym_cnt == '0) && (head_first != (bus_cnt == '0)));
      count_nxt = count + {1'b0, wr} - {1'b0, pop};
      case (state)
         IDLE:    if (count_nxt != 2'd0) state_nxt = SEND;
         SEND:    if (count_nxt == 2'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_st or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Buffer storage carries no reset; occupancy is tracked by count.
   always_ff @(posedge clk_st) begin
      if (wr) begin
         mem_data[wr_ptr]  <= bus_data;
         mem_first[wr_ptr] <= bus_first;
      end
   end

   always_ff @(posedge clk_st or posedge rst) begin
      if (rst) begin
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         bus_ready <= 1'b1;
         sym_cnt   <= '0;
         bus_cnt   <= '0;
         err_flag  <= 1'b0;
         st_data   <= '0;
         st_valid  <= 1'b0;
         st_sop    <= 1'b0;
         st_eop    <= 1'b0;
         st_error  <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= ~wr_ptr;
         if (pop) rd_ptr <= ~rd_ptr;
         count     <= count_nxt;
         bus_ready <= (count_nxt != 2'd2);
         if (emit) begin
            st_data  <= head_data[sym_cnt*ST +: ST];
            st_valid <= 1'b1;
            st_sop   <= sop_nxt;
            st_eop   <= eop_nxt;
            st_error <= eop_nxt && err_nxt;
            err_flag <= err_nxt;
            sym_cnt  <= sym_last ? '0 : sym_cnt + 1'b1;
            if (sym_last) bus_cnt <= (bus_cnt == BUS_LAST) ? '0 : bus_cnt + 1'b1;
         end else if (adv) begin
            st_valid <= 1'b0;
         end
      end
   end

`ifdef BUS2ST_PKT_CNT_EN
   always_ff @(posedge clk_st or posedge rst) begin
      if (rst)                              pkt_cnt <= 16'd0;
      else if (st_valid && st_ready && st_eop) pkt_cnt <= pkt_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_bus2st_ser.sv
`timescale 1ns/1ps
module tb_bus2st_ser;
   localparam int NSYM = 64;
   localparam int BPP  = 2;
   localparam int PKT  = 128;

   logic         clk_st = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] bus_data = '0;
   logic         bus_first = 1'b0;
   logic         bus_en = 1'b0;
   logic         bus_ready;
   logic         st_ready = 1'b0;
   logic [7:0]   st_data;
   logic         st_valid, st_sop, st_eop, st_error;
`ifdef BUS2ST_PKT_CNT_EN
   logic [15:0]  pkt_cnt;
`endif

   always #5 clk_st = ~clk_st;

   bus2st_ser #(.ST_PER_BUS(512), .ST(8), .NUM_ST_PER_BUS(64), .ST_PER_TURBO_PKT(128)) dut (
      .clk_st(clk_st), .rst(rst), .bus_data(bus_data), .bus_first(bus_first),
      .bus_en(bus_en), .bus_ready(bus_ready), .st_ready(st_ready), .st_data(st_data),
      .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
`ifdef BUS2ST_PKT_CNT_EN
      .pkt_cnt(pkt_cnt),
`endif
      .st_error(st_error));

   typedef struct { logic [511:0] data; logic first; } word_t;
   typedef struct { logic [7:0] data; logic sop; logic eop; logic err; } beat_t;
   typedef struct { logic f0; logic f1; int mode; int base; int exp_vc; logic exp_err; } vec_t;

   word_t feed_q[$];
   word_t words[$];
   beat_t obs[$];
   int    n_chk = 0, n_pass = 0;
   int    acc_cnt = 0, hs_cnt = 0, pkt_model = 0, checked = 0;
   int    ready_mode = 0;
   logic  rdy_phase = 1'b1;
   bit    gap_en = 0;
   logic  last_vld, last_hs, last_eop;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic logic [511:0] ramp(input int start);
      logic [511:0] d;
      for (int k = 0; k < NSYM; k++) d[k*8 +: 8] = 8'(start + k);
      return d;
   endfunction

   function automatic int occupancy();
      return acc_cnt - (hs_cnt + int'(st_valid)) / NSYM;
   endfunction

   // One clock cycle: drive inputs, note pre-edge handshakes, then check
   // the post-edge state against the reference bookkeeping.
   task automatic step();
      logic hs, hold, acc, adv_pre;
      beat_t b;
      int pre_occ;
      if (feed_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
         bus_en = 1'b1; bus_data = feed_q[0].data; bus_first = feed_q[0].first;
      end else begin
         bus_en = 1'b0;
      end
      case (ready_mode)
         0: st_ready = 1'b1;
         1: begin st_ready = rdy_phase; rdy_phase = ~rdy_phase; end
         2: st_ready = 1'($urandom_range(0, 1));
         default: st_ready = 1'b0;
      endcase
      hs      = st_valid && st_ready;
      hold    = st_valid && !st_ready;
      adv_pre = !st_valid || st_ready;
      b       = '{st_data, st_sop, st_eop, st_error};
      acc     = bus_en && bus_ready;
      pre_occ = occupancy();
      last_vld = st_valid; last_hs = hs; last_eop = st_eop;
      if (hs) obs.push_back(b);
      @(posedge clk_st); #1;
      if (acc) begin words.push_back(feed_q.pop_front()); acc_cnt++; end
      if (hs) begin
         hs_cnt++;
         if (b.eop) pkt_model = (pkt_model + 1) & 16'hFFFF;
      end
      if (hold)
         chk("hold", 32'({st_valid, st_data, st_sop, st_eop, st_error}),
             32'({1'b1, b.data, b.sop, b.eop, b.err}));
      if (acc && pre_occ == 0 && adv_pre) chk("latency", 32'(st_valid), 32'd1);
      chk("bus_ready", 32'(bus_ready), 32'(occupancy() < 2));
`ifdef BUS2ST_PKT_CNT_EN
      if (hs && b.eop) chk("pkt_cnt", 32'(pkt_cnt), 32'(pkt_model));
`endif
   endtask

   // Expected stream from the words accepted: symbols in order, sop/eop by
   // position, error flag from each packet's word-position/first mismatches.
   task automatic check_stream();
      for (int i = checked; i < obs.size(); i++) begin
         int w, s, p;
         logic perr;
         beat_t e;
         w = i / NSYM; s = i % NSYM; p = i / PKT; perr = 1'b0;
         if (w < words.size()) e.data = words[w].data[s*8 +: 8];
         else e.data = 8'hxx;
         e.sop = (i % PKT == 0);
         e.eop = (i % PKT == PKT - 1);
         for (int j = p * BPP; j < (p + 1) * BPP && j < words.size(); j++)
            perr |= (words[j].first != (j % BPP == 0));
         e.err = e.eop && perr;
         chk($sformatf("stream[%0d]", i), 32'({obs[i].data, obs[i].sop, obs[i].eop, obs[i].err}),
             32'({e.data, e.sop, e.eop, e.err}));
      end
      checked = obs.size();
   endtask

   task automatic drain(input string name, input int bound);
      int n = 0;
      while ((feed_q.size() > 0 || st_valid || hs_cnt != acc_cnt * NSYM) && n < bound) begin
         step(); n++;
      end
      chk({name, "_drained"}, 32'(hs_cnt), 32'(acc_cnt * NSYM));
      chk({name, "_fed"}, 32'(feed_q.size()), 32'd0);
      check_stream();
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_outs"}, 32'({st_valid, st_sop, st_eop, st_error, st_data}), 32'd0);
      chk({name, "_bus_ready"}, 32'(bus_ready), 32'd1);
`ifdef BUS2ST_PKT_CNT_EN
      chk({name, "_pkt_cnt"}, 32'(pkt_cnt), 32'd0);
`endif
   endtask

   initial begin
      vec_t vt[6];
      int acc0, hs0, n, i0, vc;
      bit done;
      word_t wd;

      vt[0] = '{1'b1, 1'b0, 0, 8'h00, 128, 1'b0};
      vt[1] = '{1'b1, 1'b0, 1, 8'h00, 256, 1'b0};
      vt[2] = '{1'b1, 1'b1, 0, 8'h80, 128, 1'b1};
      vt[3] = '{1'b1, 1'b0, 0, 8'h10, 128, 1'b0};
      vt[4] = '{1'b0, 1'b0, 1, 8'h20, 256, 1'b1};
      vt[5] = '{1'b0, 1'b1, 0, 8'h33, 128, 1'b1};

      repeat (3) @(posedge clk_st);
      #1;
      check_reset_outputs("reset");
      @(negedge clk_st); rst = 1'b0;
      @(posedge clk_st); #1;

      // Table-driven packets: one packet per record, pipeline empty at start.
      for (int v = 0; v < 6; v++) begin
         ready_mode = vt[v].mode; rdy_phase = 1'b1;
         feed_q.push_back('{ramp(vt[v].base), vt[v].f0});
         feed_q.push_back('{ramp(vt[v].base + 64), vt[v].f1});
         i0 = obs.size(); vc = 0; done = 0; n = 0;
         while (!done && n < 1000) begin
            step(); n++;
            if (last_vld) vc++;
            if (last_hs && last_eop) done = 1;
         end
         chk($sformatf("vec%0d_cycles", v), 32'(vc), 32'(vt[v].exp_vc));
         chk($sformatf("vec%0d_beats", v), 32'(obs.size() - i0), 32'(PKT));
         for (int i = 0; i < PKT && i0 + i < obs.size(); i++)
            chk($sformatf("vec%0d_beat%0d", v, i),
                32'({obs[i0+i].data, obs[i0+i].sop, obs[i0+i].eop, obs[i0+i].err}),
                32'({8'(vt[v].base + i), i == 0, i == PKT - 1, (i == PKT - 1) && vt[v].exp_err}));
         repeat (2) step();
      end
      check_stream();

      // Back-pressure: ready held low, three words offered.
      ready_mode = 3; acc0 = acc_cnt; hs0 = hs_cnt;
      feed_q.push_back('{ramp(8'h00), 1'b1});
      feed_q.push_back('{ramp(8'h40), 1'b0});
      feed_q.push_back('{ramp(8'h90), 1'b1});
      repeat (6) step();
      chk("bp_accepts", 32'(acc_cnt - acc0), 32'd2);
      chk("bp_bus_ready", 32'(bus_ready), 32'd0);
      chk("bp_no_beats", 32'(hs_cnt - hs0), 32'd0);
      ready_mode = 0; n = 0;
      while (acc_cnt - acc0 < 3 && n < 500) begin step(); n++; end
      chk("bp_third_after", 32'(hs_cnt - hs0), 32'd64);
      feed_q.push_back('{ramp(8'hD0), 1'b0});
      drain("bp", 1000);

      // Reset in the middle of a packet, then a fresh packet.
      ready_mode = 0; hs0 = hs_cnt; n = 0;
      feed_q.push_back('{ramp(8'hA0), 1'b1});
      feed_q.push_back('{ramp(8'hE0), 1'b0});
      while (hs_cnt - hs0 < 30 && n < 200) begin step(); n++; end
      chk("mid_beats", 32'(hs_cnt - hs0), 32'd30);
      check_stream();
      rst = 1'b1; bus_en = 1'b0; #2;
      check_reset_outputs("mid_reset");
      @(negedge clk_st); rst = 1'b0;
      feed_q.delete(); words.delete(); obs.delete();
      checked = 0; acc_cnt = 0; hs_cnt = 0; pkt_model = 0;
      @(posedge clk_st); #1;
      feed_q.push_back('{ramp(8'h00), 1'b1});
      feed_q.push_back('{ramp(8'h40), 1'b0});
      step();
      chk("restart_first", 32'({st_valid, st_sop, st_data}), 32'({1'b1, 1'b1, 8'h00}));
      drain("restart", 1000);

      // Randomized traffic: random data, ready, bus gaps, occasional bad first flags.
      ready_mode = 2; gap_en = 1;
      for (int p = 0; p < 8; p++)
         for (int w = 0; w < BPP; w++) begin
            for (int k = 0; k < 16; k++) wd.data[k*32 +: 32] = $urandom;
            wd.first = (w == 0) ^ ($urandom_range(0, 9) == 0);
            feed_q.push_back(wd);
         end
      drain("random", 8000);
      gap_en = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/bus2st_ser.md
Name: bus2st_ser

Overview:
- Serializes wide parallel bus words, read from memory by the NLB AFU, into an 8-bit Avalon-ST stream with sop/eop packet framing for the turbo decoder input.
- It is the transmit-side counterpart of the decoder-output stream-to-bus path: memory -> bus2st_ser -> TurboDecoder.
- Provides a 2-word input buffer so that bus back-pressure is decoupled from st_ready.

Parameters:
- ST_PER_BUS, 512, data bits per bus word.
- ST, 8, symbol width on the ST side.
- NUM_ST_PER_BUS, 64, symbols per bus word (ST_PER_BUS/ST).
- ST_PER_TURBO_PKT, 128, symbols per turbo packet. Must be an integer multiple of NUM_ST_PER_BUS; BUS_PER_PKT = ST_PER_TURBO_PKT/NUM_ST_PER_BUS (default 2).

Ports:
- clk_st  in  1  single clock for the whole block (turbo decoder clock).
- rst  in  1  asynchronous reset, active-high.
- bus_data  in  ST_PER_BUS  bus word; symbol k = bus_data[k*ST +: ST], so symbol 0 is the LSBs and is sent first.
- bus_first  in  1  qualifies bus_data as the first word of a turbo packet.
- bus_en  in  1  word valid; a transfer occurs when bus_en && bus_ready.
- bus_ready  out  1  at least one buffer slot is free.
- st_ready  in  1  Avalon-ST ready, ready latency 0.
- st_data  out  ST  symbol.
- st_valid  out  1  symbol valid.
- st_sop  out  1  first symbol of a packet.
- st_eop  out  1  last symbol of a packet.
- st_error  out  1  framing error, qualified with st_eop.

Behaviour:
- Reset (async assert, sync deassert handled outside the block):
  - st_valid, st_sop, st_eop and st_error are 0; st_data is 0.
  - bus_ready is 1; both buffer slots are empty; all counters are 0.
- Buffer: 2-slot FIFO of {bus_data, bus_first}.
  - bus_ready = !(slot count == 2), registered.
  - A write while the FIFO is full is ignored. It cannot occur legally; the bench checks that it never happens.
  - A simultaneous write and pop with count==1 leaves count at 1.
- Serializer state: sym_cnt (0..NUM_ST_PER_BUS-1) and bus_cnt (0..BUS_PER_PKT-1), plus the states IDLE and SEND.
  - IDLE -> SEND when the FIFO is non-empty.
  - SEND -> IDLE on the last symbol of a word when the FIFO holds no further word.
- Output advance condition: adv = !st_valid || st_ready. On adv in SEND:
  - st_data is loaded with the head-word symbol sym_cnt.
  - st_valid = 1.
  - st_sop = (sym_cnt==0 && bus_cnt==0).
  - st_eop = (sym_cnt==NUM_ST_PER_BUS-1 && bus_cnt==BUS_PER_PKT-1).
  - sym_cnt increments and wraps. On wrap, the head word is popped and bus_cnt increments and wraps.
- On adv with no word available: st_valid = 0; the other outputs hold.
- When st_valid && !st_ready, all st_* outputs hold stable.
- Latency: a word accepted at cycle N with an empty pipeline gives its first symbol at st_data in cycle N+1.
- Sustained rate: 1 symbol/cycle while st_ready=1, with no bubble between words if the next word is already buffered.
- Framing errors: the error flag is sticky per packet, cleared when st_sop is issued and output on st_error together with st_eop.
  - bus_first=0 on a word where bus_cnt==0 sets the flag.
  - bus_first=1 where bus_cnt!=0 sets the flag. Counters are not resynchronized; the stream keeps its length.
- Reset mid-packet discards the buffered words and the partial packet. The next output packet starts with sop.

Optional Feature:
- Macro: BUS2ST_PKT_CNT_EN.
- Defined: adds output port pkt_cnt [15:0]. It increments on each accepted eop beat (st_valid && st_ready && st_eop), wraps 0xFFFF -> 0, and is reset to 0.
- Undefined: the port and its counter are absent; behaviour is otherwise identical.

Test Plan:
- After reset, one word with bus_first=1 and bytes 0x00..0x3F, plus a second word with bytes 0x40..0x7F, st_ready=1:
  - 128 beats with st_data = 0x00..0x7F.
  - sop on beat 0, eop on beat 127, st_error=0.
  - First beat one cycle after the first accept.
- Same stimulus with st_ready toggling 1,0,1,0: data, sop and eop hold during ready=0; the sequence is unchanged; 256 cycles total.
- st_ready=0 held and 3 words offered: bus_ready falls after 2 accepts. The third word is taken only after st_ready=1 and the first word drains (64 beats).
- Second word of a packet sent with bus_first=1: st_error=1 on that packet's eop beat only. The next correct packet has st_error=0.
- rst pulse at beat 30 of a packet, then a new valid packet: the output restarts with sop and st_data=0x00; no stale data appears.
- With BUS2ST_PKT_CNT_EN defined, 3 packets sent: pkt_cnt reads 1, 2, 3 after each eop handshake.
